// File: rtl/dataint_crc_checker_if.sv
// Byte-stream handshake between the deserializer (master) and the CRC checker (slave).
interface dataint_crc_checker_if;
    logic       i_valid;
    logic [7:0] i_data;
    logic       i_last;
    logic       o_ready;

    modport master (
        output i_valid,
        output i_data,
        output i_last,
        input  o_ready
    );

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_last,
        output o_ready
    );
endinterface

// File: rtl/dataint_crc_checker.sv
// Streaming CRC checker: folds payload bytes into an MSB-first CRC while the
// trailing CRC_WIDTH/8 bytes sit in a delay line, then compares at frame end.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FILL   | delay line not yet full; bytes only load the delay line
// S_STREAM | delay line full; each new byte pushes the oldest into the CRC
// S_DONE   | one-cycle result slot; not ready, reload CRC/clear line
module dataint_crc_checker #(
    parameter int CRC_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    dataint_crc_checker_if.slave s_if,
    input  logic [CRC_WIDTH-1:0] i_poly,
    input  logic [CRC_WIDTH-1:0] i_init,
    input  logic [CRC_WIDTH-1:0] i_xorout,
    output logic                 o_done,
    output logic                 o_crc_ok,
    output logic                 o_err_short,
    output logic [CRC_WIDTH-1:0] o_crc_computed,
    output logic [CRC_WIDTH-1:0] o_crc_received
);

    localparam int N  = CRC_WIDTH / 8;
    localparam int FW = 4;

    typedef enum logic [1:0] {
        S_FILL,
        S_STREAM,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CRC_WIDTH-1:0] crc_q, crc_d;
    logic [CRC_WIDTH-1:0] dly_q, dly_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 ok_q, ok_d;
    logic                 short_q, short_d;
    logic [CRC_WIDTH-1:0] comp_q, comp_d;
    logic [CRC_WIDTH-1:0] recv_q, recv_d;

    logic                 accept;
    logic [CRC_WIDTH-1:0] shifted;
    logic [CRC_WIDTH-1:0] crc_push;
    logic [FW-1:0]        fill_inc;

    // Eight chained MSB-first shift/XOR steps, bit 7 of the byte first.
    function automatic logic [CRC_WIDTH-1:0] crc_byte(
        input logic [CRC_WIDTH-1:0] c_in,
        input logic [7:0]           b,
        input logic [CRC_WIDTH-1:0] poly
    );
        logic [CRC_WIDTH-1:0] c;
        logic                 fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[CRC_WIDTH-1] ^ b[3'(i)];
            c  = (c << 1) ^ (fb ? poly : '0);
        end
        return c;
    endfunction

    assign s_if.o_ready   = ready_q;
    assign o_done         = done_q;
    assign o_crc_ok       = ok_q;
    assign o_err_short    = short_q;
    assign o_crc_computed = comp_q;
    assign o_crc_received = recv_q;

    // Next-state, datapath and result computation.
    always_comb begin
        accept   = s_if.i_valid & ready_q;
        shifted  = (dly_q << 8) | CRC_WIDTH'(s_if.i_data);
        crc_push = crc_byte(crc_q, dly_q[CRC_WIDTH-1 -: 8], i_poly);
        fill_inc = fill_q + 1'b1;

        state_d = state_q;
        crc_d   = crc_q;
        dly_d   = dly_q;
        fill_d  = fill_q;
        done_d  = 1'b0;
        ok_d    = ok_q;
        short_d = short_q;
        comp_d  = comp_q;
        recv_d  = recv_q;

        case (state_q)
            S_FILL: begin
                // Nothing is folded while filling, so the CRC just tracks i_init.
                crc_d = i_init;
                if (accept) begin
                    dly_d  = shifted;
                    fill_d = fill_inc;
                    if (s_if.i_last) begin
                        comp_d  = i_init ^ i_xorout;
                        recv_d  = shifted;
                        short_d = (fill_inc != FW'(N));
                        ok_d    = (fill_inc == FW'(N)) && ((i_init ^ i_xorout) == shifted);
                        state_d = S_DONE;
                    end else if (fill_inc == FW'(N)) begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (accept) begin
                    crc_d = crc_push;
                    dly_d = shifted;
                    if (s_if.i_last) begin
                        comp_d  = crc_push ^ i_xorout;
                        recv_d  = shifted;
                        short_d = 1'b0;
                        ok_d    = ((crc_push ^ i_xorout) == shifted);
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                crc_d   = i_init;
                dly_d   = '0;
                fill_d  = '0;
                state_d = S_FILL;
            end
            default: begin
                state_d = S_FILL;
            end
        endcase

        done_d  = (state_d == S_DONE);
        ready_d = (state_d != S_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_FILL;
            crc_q   <= '0;
            dly_q   <= '0;
            fill_q  <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            short_q <= 1'b0;
            comp_q  <= '0;
            recv_q  <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            dly_q   <= dly_d;
            fill_q  <= fill_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            short_q <= short_d;
            comp_q  <= comp_d;
            recv_q  <= recv_d;
        end
    end

endmodule

// File: tb/tb_dataint_crc_checker.sv
// Scoreboard bench for dataint_crc_checker at CRC widths 32, 16 and 8.
module tb_dataint_crc_checker;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    int         sel;

    logic [31:0] poly32, init32, xor32;
    logic [15:0] poly16, init16, xor16;
    logic [7:0]  poly8, init8, xor8;

    logic        done32, ok32, short32;
    logic [31:0] comp32, recv32;
    logic        done16, ok16, short16;
    logic [15:0] comp16, recv16;
    logic        done8, ok8, short8;
    logic [7:0]  comp8, recv8;

    logic        ready_sel, done_sel, ok_sel, short_sel;
    logic [31:0] comp_sel, recv_sel;

    typedef struct {
        logic        ok;
        logic        short_f;
        logic [31:0] comp;
        logic [31:0] recv;
    } exp_t;
    exp_t sb[$];

    dataint_crc_checker_if if32 ();
    dataint_crc_checker_if if16 ();
    dataint_crc_checker_if if8 ();

    assign if32.i_valid = s_valid && (sel == 0);
    assign if16.i_valid = s_valid && (sel == 1);
    assign if8.i_valid  = s_valid && (sel == 2);
    assign if32.i_data  = s_data;
    assign if16.i_data  = s_data;
    assign if8.i_data   = s_data;
    assign if32.i_last  = s_last;
    assign if16.i_last  = s_last;
    assign if8.i_last   = s_last;

    dataint_crc_checker #(.CRC_WIDTH(32)) dut32 (
        .i_clk(clk), .i_rst(rst), .s_if(if32),
        .i_poly(poly32), .i_init(init32), .i_xorout(xor32),
        .o_done(done32), .o_crc_ok(ok32), .o_err_short(short32),
        .o_crc_computed(comp32), .o_crc_received(recv32)
    );
    dataint_crc_checker #(.CRC_WIDTH(16)) dut16 (
        .i_clk(clk), .i_rst(rst), .s_if(if16),
        .i_poly(poly16), .i_init(init16), .i_xorout(xor16),
        .o_done(done16), .o_crc_ok(ok16), .o_err_short(short16),
        .o_crc_computed(comp16), .o_crc_received(recv16)
    );
    dataint_crc_checker #(.CRC_WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .s_if(if8),
        .i_poly(poly8), .i_init(init8), .i_xorout(xor8),
        .o_done(done8), .o_crc_ok(ok8), .o_err_short(short8),
        .o_crc_computed(comp8), .o_crc_received(recv8)
    );

    always_comb begin
        ready_sel = (sel == 0) ? if32.o_ready : (sel == 1) ? if16.o_ready : if8.o_ready;
        done_sel  = (sel == 0) ? done32 : (sel == 1) ? done16 : done8;
        ok_sel    = (sel == 0) ? ok32 : (sel == 1) ? ok16 : ok8;
        short_sel = (sel == 0) ? short32 : (sel == 1) ? short16 : short8;
        comp_sel  = (sel == 0) ? comp32 : (sel == 1) ? {16'h0, comp16} : {24'h0, comp8};
        recv_sel  = (sel == 0) ? recv32 : (sel == 1) ? {16'h0, recv16} : {24'h0, recv8};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference CRC: MSB-first bitwise shift/XOR over the payload, then xorout.
    function automatic logic [31:0] model_crc(input int w, input logic [31:0] poly,
                                              input logic [31:0] init, input logic [31:0] xo,
                                              input byte unsigned pl[$]);
        logic [31:0] mask;
        logic [31:0] c;
        logic [7:0]  b;
        logic        fb;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        c = init & mask;
        foreach (pl[k]) begin
            b = pl[k];
            for (int i = 7; i >= 0; i--) begin
                fb = c[w-1] ^ b[i];
                c  = ((c << 1) ^ (fb ? poly : 32'h0)) & mask;
            end
        end
        return (c ^ xo) & mask;
    endfunction

    // Scoreboard monitor: every done pulse pops one expected result.
    logic prev_done;
    initial prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done_sel) begin
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_width: done high two cycles in a row, required one");
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done=1 with no frame pending, required 0");
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (ok_sel !== e.ok) begin
                        errors++;
                        $display("FAIL crc_ok: got %b required %b", ok_sel, e.ok);
                    end
                    checks++;
                    if (short_sel !== e.short_f) begin
                        errors++;
                        $display("FAIL err_short: got %b required %b", short_sel, e.short_f);
                    end
                    checks++;
                    if (comp_sel !== e.comp) begin
                        errors++;
                        $display("FAIL crc_computed: got %h required %h", comp_sel, e.comp);
                    end
                    checks++;
                    if (recv_sel !== e.recv) begin
                        errors++;
                        $display("FAIL crc_received: got %h required %h", recv_sel, e.recv);
                    end
                end
            end
            prev_done = done_sel;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Drives one frame starting at a negedge; returns how many cycles the first byte waited.
    task automatic send_frame(input byte unsigned bytes[$], input bit bubbles,
                              input bit has_last, input bit idle_after,
                              output int first_stall);
        int stall;
        first_stall = 0;
        for (int k = 0; k < bytes.size(); k++) begin
            if (bubbles) begin
                repeat ($urandom_range(0, 2)) begin
                    s_valid = 1'b0;
                    @(negedge clk);
                end
            end
            s_valid = 1'b1;
            s_data  = bytes[k];
            s_last  = has_last && (k == bytes.size() - 1);
            stall   = 0;
            while (!ready_sel && stall < 50) begin
                @(negedge clk);
                stall++;
            end
            if (stall >= 50) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: ready stuck at 0, required 1");
            end
            if (k == 0) first_stall = stall;
            @(negedge clk);
        end
        if (has_last) begin
            checks++;
            if (done_sel !== 1'b1) begin
                errors++;
                $display("FAIL done_latency: done=%b one cycle after last, required 1", done_sel);
            end
            checks++;
            if (ready_sel !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_done: ready=%b after last, required 0", ready_sel);
            end
        end
        if (idle_after) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (if32.o_ready !== 1'b1 || done32 !== 1'b0 || ok32 !== 1'b0 || short32 !== 1'b0 ||
            comp32 !== 32'h0 || recv32 !== 32'h0) begin
            errors++;
            $display("FAIL %s: ready=%b done=%b ok=%b short=%b comp=%h recv=%h required 1 0 0 0 0 0",
                     tag, if32.o_ready, done32, ok32, short32, comp32, recv32);
        end
    endtask

    function automatic void push_exp(input logic ok, input logic sh,
                                     input logic [31:0] comp, input logic [31:0] recv);
        exp_t e;
        e.ok = ok; e.short_f = sh; e.comp = comp; e.recv = recv;
        sb.push_back(e);
    endfunction

    byte unsigned check_str[$];

    task automatic set_bzip2();
        poly32 = 32'h04C1_1DB7;
        init32 = 32'hFFFF_FFFF;
        xor32  = 32'hFFFF_FFFF;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_during");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset_after");
    endtask

    task automatic test_bzip2();
        byte unsigned f[$];
        int st;
        sel = 0;
        set_bzip2();
        f = check_str;
        f.push_back(8'hFC); f.push_back(8'h89); f.push_back(8'h19); f.push_back(8'h18);
        push_exp(1'b1, 1'b0, 32'hFC89_1918, 32'hFC89_1918);
        send_frame(f, 1'b0, 1'b1, 1'b1, st);
        @(negedge clk);
    endtask

    task automatic test_bad_payload();
        byte unsigned pl[$];
        byte unsigned f[$];
        int st;
        sel = 0;
        set_bzip2();
        pl = check_str;
        pl[4] = 8'h36;
        f = pl;
        f.push_back(8'hFC); f.push_back(8'h89); f.push_back(8'h19); f.push_back(8'h18);
        push_exp(1'b0, 1'b0, model_crc(32, poly32, init32, xor32, pl), 32'hFC89_1918);
        send_frame(f, 1'b0, 1'b1, 1'b1, st);
        @(negedge clk);
    endtask

    task automatic test_crc8_bubbles();
        byte unsigned f[$];
        int st;
        sel = 2;
        poly8 = 8'h07; init8 = 8'h00; xor8 = 8'h00;
        f = check_str;
        f.push_back(8'hF4);
        push_exp(1'b1, 1'b0, 32'h0000_00F4, 32'h0000_00F4);
        send_frame(f, 1'b1, 1'b1, 1'b1, st);
        @(negedge clk);
    endtask

    task automatic test_crc16();
        byte unsigned f[$];
        int st;
        sel = 1;
        poly16 = 16'h1021; init16 = 16'h0000; xor16 = 16'h0000;
        f = check_str;
        f.push_back(8'h31); f.push_back(8'hC3);
        push_exp(1'b1, 1'b0, 32'h0000_31C3, 32'h0000_31C3);
        send_frame(f, 1'b0, 1'b1, 1'b1, st);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        byte unsigned f[$];
        int st0, st1;
        sel = 0;
        set_bzip2();
        f = check_str;
        f.push_back(8'hFC); f.push_back(8'h89); f.push_back(8'h19); f.push_back(8'h18);
        push_exp(1'b1, 1'b0, 32'hFC89_1918, 32'hFC89_1918);
        push_exp(1'b1, 1'b0, 32'hFC89_1918, 32'hFC89_1918);
        send_frame(f, 1'b0, 1'b1, 1'b0, st0);
        send_frame(f, 1'b0, 1'b1, 1'b1, st1);
        checks++;
        if (st1 !== 1) begin
            errors++;
            $display("FAIL b2b_stall: second frame first byte waited %0d cycles, required 1", st1);
        end
        @(negedge clk);
    endtask

    task automatic test_short();
        byte unsigned f[$];
        int st;
        sel = 0;
        set_bzip2();
        f.push_back(8'hAB); f.push_back(8'hCD);
        push_exp(1'b0, 1'b1, init32 ^ xor32, 32'h0000_ABCD);
        send_frame(f, 1'b0, 1'b1, 1'b1, st);
        @(negedge clk);
    endtask

    task automatic test_exact_n();
        byte unsigned f[$];
        int st;
        sel = 0;
        poly32 = 32'h04C1_1DB7; init32 = 32'h0; xor32 = 32'hFFFF_FFFF;
        f.push_back(8'hFF); f.push_back(8'hFF); f.push_back(8'hFF); f.push_back(8'hFF);
        push_exp(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send_frame(f, 1'b0, 1'b1, 1'b1, st);
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        byte unsigned f[$];
        int st;
        sel = 0;
        set_bzip2();
        for (int k = 0; k < 5; k++) f.push_back(check_str[k]);
        send_frame(f, 1'b0, 1'b0, 1'b1, st);
        rst = 1'b1;
        #1;
        check_reset_vals("mid_reset_immediate");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("mid_reset_after");
        test_bzip2();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        sel     = 0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        set_bzip2();
        poly16 = 16'h1021; init16 = 16'h0; xor16 = 16'h0;
        poly8  = 8'h07;    init8  = 8'h0;  xor8  = 8'h0;
        check_str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        test_reset();
        test_bzip2();
        test_bad_payload();
        test_crc8_bubbles();
        test_crc16();
        test_back_to_back();
        test_short();
        test_exact_n();
        test_mid_reset();

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_done: %0d frames without result, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dataint_crc_checker.md
# dataint_crc_checker

Streaming CRC checker: receive-side counterpart of the byte-wide CRC generator cascade. Accepts a byte stream framed by a last flag, where the final CRC_WIDTH/8 bytes of each frame are the transmitted CRC (MSB byte first). The block computes the CRC over the payload with the same MSB-first shift/XOR algorithm and compares it against the received value. It reports a one-cycle done pulse with registered pass/fail status. It sits between the byte deserializer and the frame consumer.

## Interface
- CRC_WIDTH, 32, CRC width in bits; must be a multiple of 8, range 8..64; N = CRC_WIDTH/8 CRC bytes per frame
- i_clk  input  1  clock, all logic on rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_poly  input  CRC_WIDTH  generator polynomial, implicit top bit; held stable during a frame
- i_init  input  CRC_WIDTH  CRC register start value, loaded at frame start
- i_xorout  input  CRC_WIDTH  final XOR applied to the computed CRC before compare
- i_valid  input  1  byte valid
- i_data  input  8  byte, bit 7 processed first
- i_last  input  1  marks final byte of the frame; qualified by i_valid & o_ready
- o_ready  output  1  byte accept; a byte is accepted when i_valid & o_ready
- o_done  output  1  one-cycle pulse, frame result valid
- o_crc_ok  output  1  registered; 1 when computed equals received and frame not short
- o_err_short  output  1  registered; frame had fewer than N bytes
- o_crc_computed  output  CRC_WIDTH  registered computed CRC, after xorout
- o_crc_received  output  CRC_WIDTH  registered received CRC

## Operation
- Delay line: N-byte shift register. Each accepted byte enters the delay line. Once the line holds N bytes, each further accepted byte pushes out the oldest byte, and that byte is folded into the CRC. At i_last, the delay line holds the received CRC with the first-received byte as MSB.
- Per-byte CRC update is 8 chained bit steps, bit 7 first. Each step: fb = crc[MSB] ^ bit; crc = (crc << 1) ^ (fb ? i_poly : 0), truncated to CRC_WIDTH.
- Fill counter: 0..N, saturates at N; cleared at frame end.
- FSM states:
  - S_FILL: fill count < N; accepted bytes only load the delay line. Go to S_STREAM when the accepted byte makes count N and i_last=0. An accepted i_last goes to S_DONE.
  - S_STREAM: each accepted byte pushes the oldest byte into the CRC. An accepted i_last goes to S_DONE.
  - S_DONE: single cycle. o_ready=0. Results are registered on entry. CRC register reloads i_init, fill count clears, delay line clears. Next state is S_FILL.
- Result on the i_last byte:
  - o_crc_computed = (CRC including any byte pushed out by the last byte) ^ i_xorout.
  - o_crc_received = delay line contents after the last byte shifts in.
  - Frame of exactly N bytes: zero-length payload; computed = i_init ^ i_xorout.
  - Frame of fewer than N bytes: o_err_short=1, o_crc_ok=0. o_crc_received is the partial delay line, zero-filled in the upper bytes.
- Status outputs (o_crc_ok, o_err_short, o_crc_computed, o_crc_received) hold until the next o_done.
- i_poly, i_init and i_xorout changing mid-frame: result undefined; not checked.

## Timing
- Reset values: o_ready=1, o_done=0, o_crc_ok=0, o_err_short=0, o_crc_computed=0, o_crc_received=0. State S_FILL, CRC register = i_init on the first post-reset cycle, delay line and counter 0.
- Throughput: one byte per cycle. o_ready is 1 in every state except S_DONE. Back-to-back frames therefore lose one cycle per frame.
- Latency: o_done and all status outputs are valid the cycle after the i_last byte is accepted. o_done is high for exactly that cycle.
- i_valid=0 cycles (bubbles) freeze all state.
- Reset asserted mid-frame: the partial frame is discarded, no o_done, outputs return to reset values immediately.
- i_valid high during S_DONE: the byte is not accepted. The sender holds it, and it is accepted in the following S_FILL cycle as the first byte of the next frame.

## Test plan
- CRC-32/BZIP2 (CRC_WIDTH=32, poly 0x04C11DB7, init 0xFFFFFFFF, xorout 0xFFFFFFFF): send "123456789" then FC 89 19 18, last on 0x18 -> o_done one cycle later, o_crc_ok=1, computed=received=0xFC891918.
- Same frame with payload byte '5' replaced by '6' -> o_crc_ok=0, received=0xFC891918, computed≠0xFC891918.
- CRC-8 (CRC_WIDTH=8, poly 0x07, init 0, xorout 0): "123456789" then F4 with random i_valid bubbles -> o_crc_ok=1, computed=0xF4. Then CRC-16/XMODEM (poly 0x1021, init 0, xorout 0): "123456789" then 31 C3 -> o_crc_ok=1.
- CRC_WIDTH=32, two back-to-back frames with i_valid held high -> o_ready low exactly one cycle after each last byte, both o_crc_ok=1, no byte lost or duplicated.
- CRC_WIDTH=32: 2-byte frame -> o_err_short=1, o_crc_ok=0. 4-byte frame FF FF FF FF with init 0, xorout 0xFFFFFFFF -> computed=0xFFFFFFFF, o_crc_ok=1.
- Assert i_rst after 5 bytes of a frame -> no o_done, outputs at reset values. A following full valid frame passes.
